// File: rtl/fetch_decode_if.sv
// Instruction-memory read bus between the fetch front end and memory.
// Address and data widths are MSB indices, matching the core parameters.
interface fetch_decode_if #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
);
  logic [ADDR_WIDTH:0] o_read_fetch_addr;
  logic [DATA_WIDTH:0] i_read_fetch_data;

  modport master (
    output o_read_fetch_addr,
    input  i_read_fetch_data
  );

  modport slave (
    input  o_read_fetch_addr,
    output i_read_fetch_data
  );
endinterface

// File: rtl/fetch_decode.sv
// RV32I front end: combinational fetch plus one-cycle registered decode.
// o_valid flags whether the previously fetched word is a legal RV32I instruction.
module fetch_decode #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [31:0] i_pc,
  fetch_decode_if.master bus,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [31:0] o_imm
);

  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } dec_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_branch, is_load, is_store, is_opimm;
  logic is_op, is_fence, is_system;

  logic fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;

  logic [31:0] imm;
  logic        legal;
  dec_t        dec_d;
  dec_t        dec_q;

  // Fetch path: pure wiring, never gated by clk_en or rst.
  assign bus.o_read_fetch_addr = (ADDR_WIDTH + 1)'(i_pc);
  assign instr = bus.i_read_fetch_data[31:0];
  assign o_instruction = instr;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign is_lui    = (opc == OP_LUI);
  assign is_auipc  = (opc == OP_AUIPC);
  assign is_jal    = (opc == OP_JAL);
  assign is_jalr   = (opc == OP_JALR);
  assign is_branch = (opc == OP_BRANCH);
  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_opimm  = (opc == OP_IMM);
  assign is_op     = (opc == OP_OP);
  assign is_fence  = (opc == OP_FENCE);
  assign is_system = (opc == OP_SYSTEM);

  assign fmt_i = is_load | is_opimm
               | is_jalr | is_system;
  assign fmt_s = is_store;
  assign fmt_b = is_branch;
  assign fmt_u = is_lui | is_auipc;
  assign fmt_j = is_jal;

  always_comb begin
    imm = 32'd0;
    unique case (1'b1)
      fmt_i: imm = {{20{instr[31]}},
                    instr[31:20]};
      fmt_s: imm = {{20{instr[31]}},
                    instr[31:25],
                    instr[11:7]};
      fmt_b: imm = {{19{instr[31]}},
                    instr[31],
                    instr[7],
                    instr[30:25],
                    instr[11:8],
                    1'b0};
      fmt_u: imm = {instr[31:12],
                    12'd0};
      fmt_j: imm = {{11{instr[31]}},
                    instr[31],
                    instr[19:12],
                    instr[20],
                    instr[30:21],
                    1'b0};
      default: imm = 32'd0;
    endcase
  end

  // Opcode compares cover instr[1:0]==2'b11 implicitly.
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc, is_jal:
        legal = 1'b1;
      is_jalr:
        legal = (f3 == 3'b000);
      is_branch:
        legal = (f3 != 3'b010)
             && (f3 != 3'b011);
      is_load:
        legal = (f3 == 3'b000)
             || (f3 == 3'b001)
             || (f3 == 3'b010)
             || (f3 == 3'b100)
             || (f3 == 3'b101);
      is_store:
        legal = (f3 == 3'b000)
             || (f3 == 3'b001)
             || (f3 == 3'b010);
      is_opimm: begin
        if (f3 == 3'b001)
          legal = (f7 == F7_ZERO);
        else if (f3 == 3'b101)
          legal = (f7 == F7_ZERO)
               || (f7 == F7_ALT);
        else
          legal = 1'b1;
      end
      is_op:
        legal = (f7 == F7_ZERO)
             || ((f7 == F7_ALT)
              && ((f3 == 3'b000)
               || (f3 == 3'b101)));
      is_fence:
        legal = (f3 == 3'b000);
      is_system:
        legal = (instr == 32'h0000_0073)
             || (instr == 32'h0010_0073);
      default:
        legal = 1'b0;
    endcase
  end

  always_comb begin
    dec_d        = '0;
    dec_d.valid  = legal;
    dec_d.opcode = opc;
    dec_d.rd     = instr[11:7];
    dec_d.rs1    = instr[19:15];
    dec_d.rs2    = instr[24:20];
    dec_d.funct3 = f3;
    dec_d.funct7 = f7;
    dec_d.imm    = imm;
  end

  always_ff @(posedge clk) begin
    if (rst)
      dec_q <= '0;
    else if (clk_en)
      dec_q <= dec_d;
  end

  assign o_valid  = dec_q.valid;
  assign o_opcode = dec_q.opcode;
  assign o_rd     = dec_q.rd;
  assign o_rs1    = dec_q.rs1;
  assign o_rs2    = dec_q.rs2;
  assign o_funct3 = dec_q.funct3;
  assign o_funct7 = dec_q.funct7;
  assign o_imm    = dec_q.imm;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed vectors, a reference decoder model
// checked every cycle, and hand-computed literal expectations.
module tb_fetch_decode;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        valid;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  int checks;
  int failures;

  fetch_decode_if bus ();

  fetch_decode dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .i_pc          (pc),
    .bus           (bus.master),
    .o_instruction (instruction),
    .o_valid       (valid),
    .o_opcode      (opcode),
    .o_rd          (rd),
    .o_rs1         (rs1),
    .o_rs2         (rs2),
    .o_funct3      (funct3),
    .o_funct7      (funct7),
    .o_imm         (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference decoder: legality by membership rules.
  function automatic bit m_legal(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    case (op)
      7'h37, 7'h17, 7'h6F: return 1'b1;
      7'h67: return f3 == 3'd0;
      7'h63: return !(f3 inside {3'd2, 3'd3});
      7'h03: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      7'h23: return f3 inside {3'd0, 3'd1, 3'd2};
      7'h13: begin
        if (f3 == 3'd1) return f7 == 7'd0;
        if (f3 == 3'd5) return f7 inside {7'd0, 7'd32};
        return 1'b1;
      end
      7'h33: return (f7 == 7'd0)
                 || (f7 == 7'd32 && f3 inside {3'd0, 3'd5});
      7'h0F: return f3 == 3'd0;
      7'h73: return (w == 32'h0000_0073) || (w == 32'h0010_0073);
      default: return 1'b0;
    endcase
  endfunction

  // Immediates via arithmetic shifts of the signed word.
  function automatic logic [31:0] m_imm(input logic [31:0] w);
    logic signed [31:0] s;
    logic [31:0] sx;
    s  = w;
    sx = 32'(s >>> 31);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73:
        return 32'(s >>> 20);
      7'h23:
        return (32'(s >>> 25) << 5) | 32'(w[11:7]);
      7'h63:
        return (sx << 12) | (32'(w[7]) << 11)
             | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      7'h37, 7'h17:
        return w & 32'hFFFF_F000;
      7'h6F:
        return (sx << 20) | (32'(w[19:12]) << 12)
             | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default:
        return 32'd0;
    endcase
  endfunction

  logic        e_known;
  logic        e_valid;
  logic [31:0] e_word;
  logic [31:0] e_imm;

  // Expected registered state, derived from inputs seen at each edge.
  always @(posedge clk) begin
    if (rst) begin
      e_known <= 1'b1;
      e_valid <= 1'b0;
      e_word  <= 32'd0;
      e_imm   <= 32'd0;
    end else if (clk_en && e_known) begin
      e_valid <= m_legal(bus.i_read_fetch_data);
      e_word  <= bus.i_read_fetch_data;
      e_imm   <= m_imm(bus.i_read_fetch_data);
    end
  end

  always @(negedge clk) begin
    chk("fetch_addr", bus.o_read_fetch_addr, pc);
    chk("instruction", instruction, bus.i_read_fetch_data);
    if (e_known === 1'b1) begin
      chk("m_valid", 32'(valid), 32'(e_valid));
      chk("m_opcode", 32'(opcode), 32'(e_word[6:0]));
      chk("m_rd", 32'(rd), 32'(e_word[11:7]));
      chk("m_rs1", 32'(rs1), 32'(e_word[19:15]));
      chk("m_rs2", 32'(rs2), 32'(e_word[24:20]));
      chk("m_funct3", 32'(funct3), 32'(e_word[14:12]));
      chk("m_funct7", 32'(funct7), 32'(e_word[31:25]));
      chk("m_imm", imm, e_imm);
    end
  end

  task automatic step(input logic [31:0] w);
    bus.i_read_fetch_data = w;
    @(posedge clk);
    #1;
    pc = pc + 32'd1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_opcode"}, 32'(opcode), 32'd0);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_rs1"}, 32'(rs1), 32'd0);
    chk({tag, "_rs2"}, 32'(rs2), 32'd0);
    chk({tag, "_funct3"}, 32'(funct3), 32'd0);
    chk({tag, "_funct7"}, 32'(funct7), 32'd0);
    chk({tag, "_imm"}, imm, 32'd0);
  endtask

  logic [31:0] vec [16];

  initial begin
    checks   = 0;
    failures = 0;
    e_known  = 1'b0;
    e_valid  = 1'b0;
    e_word   = 32'd0;
    e_imm    = 32'd0;
    rst      = 1'b1;
    clk_en   = 1'b0;
    pc       = 32'd0;
    bus.i_read_fetch_data = 32'h0050_0093;

    step(32'h0050_0093);
    step(32'h0050_0093);
    chk_zero("reset");
    pc = 32'hDEAD_BEEF;
    #1;
    chk("addr_follows_pc", bus.o_read_fetch_addr, 32'hDEAD_BEEF);
    pc = 32'd0;

    rst    = 1'b0;
    clk_en = 1'b1;
    step(32'h0050_0093);
    chk("addi_valid", 32'(valid), 32'd1);
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_rs1", 32'(rs1), 32'd0);
    chk("addi_imm", imm, 32'd5);

    step(32'h4020_8033);
    chk("sub_valid", 32'(valid), 32'd1);
    chk("sub_funct7", 32'(funct7), 32'h20);
    chk("sub_rs1", 32'(rs1), 32'd1);
    chk("sub_rs2", 32'(rs2), 32'd2);
    chk("sub_imm", imm, 32'd0);

    step(32'h0220_8033);
    chk("mul_valid", 32'(valid), 32'd0);
    step(32'h0000_0000);
    chk("zero_valid", 32'(valid), 32'd0);

    step(32'hFE00_0EE3);
    chk("beq_valid", 32'(valid), 32'd1);
    chk("beq_imm", imm, 32'hFFFF_FFFC);

    step(32'h1234_50B7);
    chk("lui_imm", imm, 32'h1234_5000);
    step(32'hFFDF_F0EF);
    chk("jal_imm", imm, 32'hFFFF_FFFC);
    step(32'hFE11_2E23);
    chk("sw_imm", imm, 32'hFFFF_FFFC);
    step(32'h0010_0073);
    chk("ebreak_valid", 32'(valid), 32'd1);

    vec = '{32'h0000_0073, 32'h0020_0073, 32'hFFFF_FFFF,
            32'h0000_300F, 32'h0000_000F, 32'h4051_5093,
            32'h4011_1093, 32'h0011_1093, 32'h0000_3003,
            32'h0000_5003, 32'h0000_3023, 32'h0000_2063,
            32'h0000_1067, 32'h8000_0067, 32'h4020_9033,
            32'h4020_A033};
    foreach (vec[i]) step(vec[i]);

    step(32'h0050_0093);
    clk_en = 1'b0;
    step(32'h4020_8033);
    step(32'hFFFF_FFFF);
    step(32'h0000_0000);
    chk("hold_valid", 32'(valid), 32'd1);
    chk("hold_rd", 32'(rd), 32'd1);
    chk("hold_opcode", 32'(opcode), 32'h13);
    chk("hold_imm", imm, 32'd5);

    rst = 1'b1;
    step(32'h0050_0093);
    chk_zero("rst_no_en");
    rst = 1'b0;
    step(32'h0050_0093);
    chk("still_held_valid", 32'(valid), 32'd0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
